// File: rtl/dcp_pkg.sv
// Shared constants for the debug control panel: ASCII codes, request type codes
// and the state encoding of the TX formatter FSM.
package dcp_pkg;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_LA    = 8'h61;

   localparam logic TX_CHAR = 1'b0;
   localparam logic TX_HEX  = 1'b1;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_SEND_ENC = 2'd1;
   localparam logic [1:0] ST_DONE_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_SEND = ST_SEND_ENC,
      ST_DONE = ST_DONE_ENC
   } tx_state_t;

endpackage

// File: rtl/dcp_tx_formatter_if.sv
// DCP request/ack side and UART TX valid/ready side of the TX formatter.
interface dcp_tx_formatter_if #(
   parameter int unsigned DW = 32
) ();

   logic          req_tx;
   logic          type_tx;
   logic [DW-1:0] dout_tx;
   logic          ack_tx;
   logic          busy;
   logic          rdy_tx;
   logic          vld_tx;
   logic [7:0]    d_tx;

   modport master (
      output req_tx, type_tx, dout_tx, rdy_tx,
      input  ack_tx, busy, vld_tx, d_tx
   );

   modport slave (
      input  req_tx, type_tx, dout_tx, rdy_tx,
      output ack_tx, busy, vld_tx, d_tx
   );

endinterface

// File: rtl/dcp_tx_formatter_nibble_to_ascii.sv
// Combinational nibble to ASCII hex digit converter.
module nibble_to_ascii
   import dcp_pkg::*;
#(
   parameter bit HEX_UPPER = 1'b1
) (
   input  logic [3:0] nib,
   output logic [7:0] asc_c
);

   localparam logic [7:0] ALPHA_BASE = HEX_UPPER ? ASCII_A : ASCII_LA;

   always_comb begin
      if (nib < 4'd10) asc_c = ASCII_0 + 8'(nib);
      else             asc_c = ALPHA_BASE + 8'(nib) - 8'd10;
   end

endmodule

// File: rtl/dcp_tx_formatter.sv
// DCP output stage: turns one print request (char or hex word) into a byte
// stream on a valid/ready link and acks the DCP when the last byte is taken.
module dcp_tx_formatter
   import dcp_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter bit          HEX_UPPER = 1'b1
) (
   input logic              clk,
   input logic              rst,
   dcp_tx_formatter_if.slave bus
);

   localparam int unsigned NDIG = DW / 4;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   tx_state_t     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, idx_c;
   logic [DW-1:0] word, word_nxt;
   logic          vld, vld_nxt;
   logic [7:0]    d, d_nxt;
   logic          ack, ack_nxt;
   logic          busy, busy_nxt;
   logic [3:0]    nib_c;
   logic [7:0]    asc_c;

   // In IDLE the converter previews the top digit of the incoming word,
   // otherwise it prepares the digit after the one currently on d_tx.
   assign idx_c = cnt - CW'(1);
   always_comb begin
      if (state == ST_IDLE) nib_c = bus.dout_tx[DW-1 -: 4];
      else                  nib_c = word[{idx_c, 2'b00} +: 4];
   end

   nibble_to_ascii #(.HEX_UPPER(HEX_UPPER)) u_n2a (
      .nib   (nib_c),
      .asc_c (asc_c)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      word_nxt  = word;
      vld_nxt   = vld;
      d_nxt     = d;
      unique case (state)
         ST_IDLE: begin
            if (bus.req_tx) begin
               word_nxt  = bus.dout_tx;
               cnt_nxt   = (bus.type_tx == TX_HEX) ? CW'(NDIG - 1) : '0;
               d_nxt     = (bus.type_tx == TX_HEX) ? asc_c : bus.dout_tx[7:0];
               vld_nxt   = 1'b1;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (vld && bus.rdy_tx) begin
               if (cnt == '0) begin
                  vld_nxt   = 1'b0;
                  state_nxt = ST_DONE;
               end else begin
                  cnt_nxt = idx_c;
                  d_nxt   = asc_c;
               end
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      ack_nxt  = (state_nxt == ST_DONE);
      busy_nxt = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         word  <= '0;
         vld   <= 1'b0;
         d     <= 8'h00;
         ack   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         word  <= word_nxt;
         vld   <= vld_nxt;
         d     <= d_nxt;
         ack   <= ack_nxt;
         busy  <= busy_nxt;
      end
   end

   assign bus.vld_tx = vld;
   assign bus.d_tx   = d;
   assign bus.ack_tx = ack;
   assign bus.busy   = busy;

endmodule

// File: tb/tb_dcp_tx_formatter.sv
// Bench for dcp_tx_formatter: upper- and lower-case instances share one stimulus
// stream and are both scored against a transaction-level byte-queue model.
module tb_dcp_tx_formatter;
   import dcp_pkg::*;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dcp_tx_formatter_if #(.DW(32)) bus_u ();
   dcp_tx_formatter_if #(.DW(32)) bus_l ();

   dcp_tx_formatter #(.DW(32), .HEX_UPPER(1'b1)) dut_u (.clk(clk), .rst(rst), .bus(bus_u));
   dcp_tx_formatter #(.DW(32), .HEX_UPPER(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

   assign bus_l.req_tx  = bus_u.req_tx;
   assign bus_l.type_tx = bus_u.type_tx;
   assign bus_l.dout_tx = bus_u.dout_tx;
   assign bus_l.rdy_tx  = bus_u.rdy_tx;

   int n_checks = 0;
   int n_fail   = 0;
   int n_ack_u  = 0;
   int n_accept = 0;
   int rdy_mode = 0;
   bit mon_en   = 1'b0;
   bit m_busy   = 1'b0;
   bit m_ack    = 1'b0;
   bq_t q_u, q_l;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected byte stream of one request, built from the printf rendering of the word.
   function automatic bq_t ref_bytes(input logic typ, input logic [31:0] w, input bit upper);
      bq_t r;
      string s;
      logic [7:0] c;
      if (typ == TX_CHAR) begin
         r.push_back(w[7:0]);
         return r;
      end
      s = $sformatf("%08h", w);
      for (int i = 0; i < 8; i++) begin
         c = s[i];
         if (upper && c >= "a" && c <= "f") c = c - 8'd32;
         r.push_back(c);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       bus_u.rdy_tx = 1'b1;
         1:       bus_u.rdy_tx = 1'($urandom_range(0, 1));
         default: bus_u.rdy_tx = 1'b0;
      endcase
   end

   // Score this cycle's outputs, then advance the model to the next cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("busy_u", bus_u.busy, m_busy);
         check_eq("busy_l", bus_l.busy, m_busy);
         check_eq("ack_u", bus_u.ack_tx, m_ack);
         check_eq("ack_l", bus_l.ack_tx, m_ack);
         check_eq("vld_u", bus_u.vld_tx, q_u.size() != 0);
         check_eq("vld_l", bus_l.vld_tx, q_l.size() != 0);
         if (q_u.size() != 0) check_eq("d_tx_u", bus_u.d_tx, q_u[0]);
         if (q_l.size() != 0) check_eq("d_tx_l", bus_l.d_tx, q_l[0]);
         if (bus_u.ack_tx === 1'b1) n_ack_u++;
         if (rst) begin
            q_u.delete();
            q_l.delete();
            m_busy = 1'b0;
            m_ack  = 1'b0;
         end else if (m_ack) begin
            m_ack  = 1'b0;
            m_busy = 1'b0;
         end else if (m_busy) begin
            if (bus_u.rdy_tx === 1'b1 && q_u.size() != 0) begin
               void'(q_u.pop_front());
               if (q_l.size() != 0) void'(q_l.pop_front());
               if (q_u.size() == 0) m_ack = 1'b1;
            end
         end else if (bus_u.req_tx === 1'b1) begin
            q_u    = ref_bytes(bus_u.type_tx, bus_u.dout_tx, 1'b1);
            q_l    = ref_bytes(bus_u.type_tx, bus_u.dout_tx, 1'b0);
            m_busy = 1'b1;
            n_accept++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Hold a request for n cycles, then scramble the inputs.
   task automatic issue(input logic typ, input logic [31:0] w, input int n);
      bus_u.type_tx = typ;
      bus_u.dout_tx = w;
      bus_u.req_tx  = 1'b1;
      tick(n);
      bus_u.req_tx  = 1'b0;
      bus_u.type_tx = 1'($urandom);
      bus_u.dout_tx = $urandom;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (m_busy && k < 400) begin
         tick(1);
         k++;
      end
      if (k >= 400) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout waiting for idle, busy=%0b", tag, bus_u.busy);
      end
   endtask

   task automatic wait_ack(input string tag);
      int k = 0;
      while (bus_u.ack_tx !== 1'b1 && k < 400) begin
         tick(1);
         k++;
      end
      if (k >= 400) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout waiting for ack, ack=%0b", tag, bus_u.ack_tx);
      end
   endtask

   initial begin
      int a0, c0;
      bus_u.req_tx  = 1'b0;
      bus_u.type_tx = 1'b0;
      bus_u.dout_tx = '0;
      rst = 1'b1;
      tick(3);
      check_eq("rst_vld", bus_u.vld_tx, 1'b0);
      check_eq("rst_d_tx", bus_u.d_tx, 8'h00);
      check_eq("rst_ack", bus_u.ack_tx, 1'b0);
      check_eq("rst_busy", bus_u.busy, 1'b0);
      mon_en = 1'b1;
      rst = 1'b0;
      tick(2);

      rdy_mode = 0;
      issue(TX_CHAR, 32'h0000_0044, 1);
      wait_idle("t1");
      tick(1);

      a0 = n_ack_u;
      issue(TX_HEX, 32'hDEAD_BEEF, 1);
      wait_idle("t2");
      check_eq("t2_acks", 32'(n_ack_u - a0), 32'd1);
      tick(1);

      rdy_mode = 1;
      issue(TX_HEX, 32'h0000_3000, 1);
      wait_idle("t3");
      rdy_mode = 0;
      tick(1);

      a0 = n_ack_u;
      c0 = n_accept;
      issue(TX_HEX, 32'hDEAD_BEEF, 1);
      tick(3);
      issue(TX_HEX, 32'h1234_5678, 2);
      wait_idle("t4");
      check_eq("t4_acks", 32'(n_ack_u - a0), 32'd1);
      check_eq("t4_accepts", 32'(n_accept - c0), 32'd1);
      tick(1);

      a0 = n_ack_u;
      issue(TX_HEX, 32'hDEAD_BEEF, 1);
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_eq("t5_vld", bus_u.vld_tx, 1'b0);
      check_eq("t5_busy", bus_u.busy, 1'b0);
      tick(12);
      check_eq("t5_no_ack", 32'(n_ack_u - a0), 32'd0);
      issue(TX_CHAR, 32'h0000_000A, 1);
      wait_idle("t5b");
      tick(1);

      rdy_mode = 2;
      issue(TX_HEX, $urandom, 1);
      tick(20);
      check_eq("stall_vld", bus_u.vld_tx, 1'b1);
      rdy_mode = 0;
      wait_idle("stall");
      tick(1);

      a0 = n_ack_u;
      c0 = n_accept;
      issue(TX_HEX, 32'hABCD_EF09, 1);
      wait_ack("b2b_ack");
      tick(1);
      issue(TX_CHAR, 32'(ASCII_CR), 1);
      wait_idle("b2b");
      check_eq("b2b_acks", 32'(n_ack_u - a0), 32'd2);
      check_eq("b2b_accepts", 32'(n_accept - c0), 32'd2);

      for (int i = 0; i < 60; i++) begin
         logic        typ;
         logic [31:0] w;
         typ = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       w = 32'(ASCII_LF);
            1:       w = 32'(ASCII_SPACE);
            default: w = $urandom;
         endcase
         rdy_mode = int'($urandom_range(0, 1));
         issue(typ, w, int'($urandom_range(1, 3)));
         tick(int'($urandom_range(0, 4)));
         if ($urandom_range(0, 2) == 0) wait_idle("rand");
      end
      rdy_mode = 0;
      wait_idle("final");
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
